score_keeper: RTL and testbench

Upstream stage of score_display. Counts goals for player and enemy and detects the end of the game. Converts each count to a score_t glyph bitmap through a digit font. Bitmaps change only at frame boundaries, so the renderer never shows a half-updated digit. In GAME_OVER, the winner's digit blinks.

---
 rtl/score_keeper_pkg.sv | 30 +++
 rtl/score_keeper_if.sv | 23 ++
 rtl/score_keeper_font.sv | 17 +
 rtl/score_keeper.sv | 106 ++++++++++
 tb/tb_score_keeper.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/score_keeper_pkg.sv
// Shared types and the digit font for the score keeper and its renderer.
package score_keeper_pkg;

    localparam int DIGIT_W = 4;
    localparam int SCORE_W = 4;
    localparam int SCORE_H = 5;

    typedef logic [DIGIT_W-1:0]              digit_t;
    typedef logic [SCORE_H-1:0][SCORE_W-1:0] score_t;

    typedef enum logic {
        RUN,
        GAME_OVER
    } state_t;

    // 4x5 glyphs, top row in the most significant nibble.
    localparam score_t FONT [0:9] = '{
        20'hF999F,
        20'h26227,
        20'hF1F8F,
        20'hF171F,
        20'h99F11,
        20'hF8F1F,
        20'hF8F9F,
        20'hF1244,
        20'hF9F9F,
        20'hF9F1F
    };

endpackage

// File: rtl/score_keeper_if.sv
// Event inputs and glyph/status outputs of the score keeper.
interface score_keeper_if
    import score_keeper_pkg::*;
();
    logic   frame_start_i;
    logic   player_goal_i;
    logic   enemy_goal_i;
    logic   new_game_i;
    score_t player_score_o;
    score_t enemy_score_o;
    logic   game_over_o;
    logic   winner_o;

    modport master (
        output frame_start_i, player_goal_i, enemy_goal_i, new_game_i,
        input  player_score_o, enemy_score_o, game_over_o, winner_o
    );

    modport slave (
        input  frame_start_i, player_goal_i, enemy_goal_i, new_game_i,
        output player_score_o, enemy_score_o, game_over_o, winner_o
    );
endinterface

// File: rtl/score_keeper_font.sv
// Digit to glyph lookup; digits outside 0..9 render blank.
module score_font
    import score_keeper_pkg::*;
(
    input  digit_t digit,
    output score_t glyph
);

    // Compare against each legal digit so the table is never indexed out of range.
    always_comb begin
        glyph = '0;
        for (int i = 0; i < 10; i++) begin
            if (digit == digit_t'(i)) glyph = FONT[i];
        end
    end

endmodule

// File: rtl/score_keeper.sv
// Goal counters, end-of-game detection, winner blink and frame-aligned glyph outputs.
module score_keeper
    import score_keeper_pkg::*;
#(
    parameter int unsigned WIN_SCORE    = 9,
    parameter int unsigned BLINK_FRAMES = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    score_keeper_if.slave bus
);

    localparam int unsigned BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam digit_t               WIN_D      = digit_t'(WIN_SCORE);
    localparam logic [BLINK_W-1:0]   BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

    state_t             state_q, state_d;
    digit_t             p_cnt_q, p_cnt_d;
    digit_t             e_cnt_q, e_cnt_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_on_q, blink_on_d;
    logic               winner_q, winner_d;
    score_t             p_score_q, e_score_q;
    score_t             p_glyph, e_glyph;
    logic               p_inc, e_inc;

    score_font u_font_player (.digit(p_cnt_q), .glyph(p_glyph));
    score_font u_font_enemy  (.digit(e_cnt_q), .glyph(e_glyph));

    // State, counters and shadow glyphs; glyphs load only on frame start.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= RUN;
            p_cnt_q     <= '0;
            e_cnt_q     <= '0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
            winner_q    <= 1'b0;
            p_score_q   <= FONT[0];
            e_score_q   <= FONT[0];
        end else begin
            state_q     <= state_d;
            p_cnt_q     <= p_cnt_d;
            e_cnt_q     <= e_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
            winner_q    <= winner_d;
            if (bus.frame_start_i) begin
                // blink_on_q is only ever low in GAME_OVER, so no state check needed.
                p_score_q <= (!blink_on_q && !winner_q) ? '0 : p_glyph;
                e_score_q <= (!blink_on_q &&  winner_q) ? '0 : e_glyph;
            end
        end
    end

    // Next state: scoring in RUN, blink timing in GAME_OVER, new game overrides both.
    always_comb begin
        state_d     = state_q;
        p_cnt_d     = p_cnt_q;
        e_cnt_d     = e_cnt_q;
        blink_cnt_d = blink_cnt_q;
        blink_on_d  = blink_on_q;
        winner_d    = winner_q;
        p_inc       = bus.player_goal_i && (p_cnt_q < WIN_D);
        e_inc       = bus.enemy_goal_i  && (e_cnt_q < WIN_D);

        case (state_q)
            RUN: begin
                p_cnt_d = p_cnt_q + digit_t'(p_inc);
                e_cnt_d = e_cnt_q + digit_t'(e_inc);
                if ((p_cnt_d == WIN_D) || (e_cnt_d == WIN_D)) begin
                    state_d     = GAME_OVER;
                    winner_d    = (p_cnt_d != WIN_D);
                    blink_cnt_d = '0;
                    blink_on_d  = 1'b1;
                end
            end
            GAME_OVER: begin
                if (bus.frame_start_i) begin
                    if (blink_cnt_q == BLINK_LAST) begin
                        blink_cnt_d = '0;
                        blink_on_d  = !blink_on_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
                    end
                end
            end
            default: state_d = RUN;
        endcase

        if (bus.new_game_i) begin
            state_d     = RUN;
            p_cnt_d     = '0;
            e_cnt_d     = '0;
            winner_d    = 1'b0;
            blink_cnt_d = '0;
            blink_on_d  = 1'b1;
        end
    end

    assign bus.player_score_o = p_score_q;
    assign bus.enemy_score_o  = e_score_q;
    assign bus.game_over_o    = (state_q == GAME_OVER);
    assign bus.winner_o       = winner_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed and random stimulus against a frame-level reference model of the score keeper.
module tb_score_keeper;
    import score_keeper_pkg::*;

    localparam int W  = 9;
    localparam int BF = 16;

    logic clk_i = 1'b0;
    logic rst_i;

    score_keeper_if sk_if ();

    score_keeper #(.WIN_SCORE(W), .BLINK_FRAMES(BF)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (sk_if.slave)
    );

    always #5 clk_i = ~clk_i;

    // Independent copy of the expected glyph shapes.
    logic [19:0] gl [0:9];

    int n_checks = 0;
    int n_fails  = 0;

    int          mp, me, mk;
    bit          mover, mwin;
    logic [19:0] exp_p, exp_e;

    task automatic check(input string tag, input logic [19:0] got, input logic [19:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the model, compare every output.
    task automatic step(input bit r, input bit fs, input bit pg, input bit eg, input bit ng);
        bit blank;
        @(negedge clk_i);
        rst_i               = r;
        sk_if.frame_start_i = fs;
        sk_if.player_goal_i = pg;
        sk_if.enemy_goal_i  = eg;
        sk_if.new_game_i    = ng;
        @(posedge clk_i);
        #1;
        if (r) begin
            mp = 0; me = 0; mk = 0; mover = 0; mwin = 0;
            exp_p = gl[0]; exp_e = gl[0];
        end else begin
            if (fs) begin
                // Winner blanked during odd blink half-periods since game over.
                blank = mover && (((mk / BF) % 2) == 1);
                exp_p = (blank && !mwin) ? 20'h0 : gl[mp];
                exp_e = (blank &&  mwin) ? 20'h0 : gl[me];
                if (mover) mk++;
            end
            if (ng) begin
                mp = 0; me = 0; mk = 0; mover = 0; mwin = 0;
            end else if (!mover) begin
                if (pg && mp < W) mp++;
                if (eg && me < W) me++;
                if (mp == W || me == W) begin
                    mover = 1;
                    mwin  = (mp != W);
                    mk    = 0;
                end
            end
        end
        check("player_score", sk_if.player_score_o, exp_p);
        check("enemy_score",  sk_if.enemy_score_o,  exp_e);
        check("game_over",    20'(sk_if.game_over_o), 20'(mover));
        check("winner",       20'(sk_if.winner_o),    20'(mwin));
    endtask

    initial begin
        gl[0] = 20'hF999F; gl[1] = 20'h26227; gl[2] = 20'hF1F8F; gl[3] = 20'hF171F;
        gl[4] = 20'h99F11; gl[5] = 20'hF8F1F; gl[6] = 20'hF8F9F; gl[7] = 20'hF1244;
        gl[8] = 20'hF9F9F; gl[9] = 20'hF9F1F;
        rst_i = 1'b1;
        sk_if.frame_start_i = 0; sk_if.player_goal_i = 0;
        sk_if.enemy_goal_i  = 0; sk_if.new_game_i    = 0;
        mp = 0; me = 0; mk = 0; mover = 0; mwin = 0;
        exp_p = gl[0]; exp_e = gl[0];

        // Reset, then three frames.
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, 0);
            step(0, 0, 0, 0, 0);
        end

        // Three player goals, then a frame.
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("p3_shown", sk_if.player_score_o, gl[3]);

        // Simultaneous goals until both reach the winning score.
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 9; i++) step(0, (i % 3) == 0, 1, 1, 0);
        step(0, 0, 0, 0, 0);
        check("tie_winner", 20'(sk_if.winner_o), 20'h0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Enemy wins 9 to 5, then 40 frames with ignored goals.
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);
        for (int f = 1; f <= 40; f++) begin
            step(0, 1, $urandom_range(0, 1), $urandom_range(0, 1), 0);
            check("blink", sk_if.enemy_score_o, (f >= 17 && f <= 32) ? 20'h0 : gl[9]);
            step(0, 0, 1, 1, 0);
            step(0, 0, 0, 0, 0);
        end

        // New game with a coincident goal, in GAME_OVER and then in RUN.
        step(0, 0, 1, 0, 1);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0);
        step(0, 0, 1, 0, 1);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Reset mid-frame with scores 4/7 and a goal held during reset.
        for (int i = 0; i < 7; i++) step(0, 0, i < 4, 1, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("pre_rst_e7", sk_if.enemy_score_o, gl[7]);
        step(1, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 499) == 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 149) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
